// File: rtl/model_matrix_pkg.sv
// Shared types and constants for the matrix element-stream source and its consumers.
// Used with or without MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN.
package model_matrix_pkg;

   localparam int DEF_DATA_SIZE    = 64;
   localparam int DEF_CONTROL_SIZE = 64;

   localparam logic [DEF_DATA_SIZE-1:0]    ZERO_DATA    = '0;
   localparam logic [DEF_DATA_SIZE-1:0]    ONE_DATA     = DEF_DATA_SIZE'(1);
   localparam logic [DEF_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
   localparam logic [DEF_CONTROL_SIZE-1:0] ONE_CONTROL  = DEF_CONTROL_SIZE'(1);

   typedef enum logic [2:0] {
      STARTER = 3'd0,
      FETCH   = 3'd1,
      LOAD    = 3'd2,
      EMIT    = 3'd3,
      WAIT    = 3'd4
   } state_t;

   // A degenerate matrix has nothing to send and completes immediately.
   function automatic logic size_is_zero(input logic [DEF_DATA_SIZE-1:0] size_a,
                                         input logic [DEF_DATA_SIZE-1:0] size_b);
      return (size_a == ZERO_DATA) || (size_b == ZERO_DATA);
   endfunction

endpackage

// File: rtl/model_matrix_index_counter.sv
// Matrix traversal counter: i/j loop indices plus a running word address, one step per element.
// MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN selects column-major order (j outer, i inner).
module model_matrix_index_counter
   import model_matrix_pkg::*;
#(
   parameter int DATA_SIZE    = DEF_DATA_SIZE,
   parameter int CONTROL_SIZE = DEF_CONTROL_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [DATA_SIZE-1:0] size_i_i,
   input  logic [DATA_SIZE-1:0] size_j_i,
   input  logic                 step_i,
   output logic [DATA_SIZE-1:0] addr_o,
   output logic                 first_o,
   output logic                 last_o
);

   localparam logic [DATA_SIZE-1:0]    ZERO_D = DATA_SIZE'(ZERO_DATA);
   localparam logic [DATA_SIZE-1:0]    ONE_D  = DATA_SIZE'(ONE_DATA);
   localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);
   localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(ONE_CONTROL);

   logic [CONTROL_SIZE-1:0] i_q, i_d;
   logic [CONTROL_SIZE-1:0] j_q, j_d;
   logic [DATA_SIZE-1:0]    size_i_q, size_i_d;
   logic [DATA_SIZE-1:0]    size_j_q, size_j_d;
   logic [DATA_SIZE-1:0]    addr_q, addr_d;
   logic                    i_wrap;
   logic                    j_wrap;

   assign i_wrap = (i_q == CONTROL_SIZE'(size_i_q - ONE_D));
   assign j_wrap = (j_q == CONTROL_SIZE'(size_j_q - ONE_D));

   assign addr_o = addr_q;
   assign last_o = i_wrap && j_wrap;
`ifdef MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN
   assign first_o = (i_q == ZERO_C);
`else
   assign first_o = (j_q == ZERO_C);
`endif

   always_comb begin
      i_d      = i_q;
      j_d      = j_q;
      size_i_d = size_i_q;
      size_j_d = size_j_q;
      addr_d   = addr_q;
      if (start_i) begin
         size_i_d = size_i_i;
         size_j_d = size_j_i;
         i_d      = ZERO_C;
         j_d      = ZERO_C;
         addr_d   = ZERO_D;
      end else if (step_i) begin
`ifdef MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN
         // Down a column the address strides by a full row; a new column restarts at row 0.
         if (!i_wrap) begin
            i_d    = i_q + ONE_C;
            addr_d = addr_q + size_j_q;
         end else begin
            i_d    = ZERO_C;
            j_d    = j_q + ONE_C;
            addr_d = DATA_SIZE'(j_q) + ONE_D;
         end
`else
         addr_d = addr_q + ONE_D;
         if (!j_wrap) begin
            j_d = j_q + ONE_C;
         end else begin
            j_d = ZERO_C;
            i_d = i_q + ONE_C;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         i_q      <= ZERO_C;
         j_q      <= ZERO_C;
         size_i_q <= ZERO_D;
         size_j_q <= ZERO_D;
         addr_q   <= ZERO_D;
      end else begin
         i_q      <= i_d;
         j_q      <= j_d;
         size_i_q <= size_i_d;
         size_j_q <= size_j_d;
         addr_q   <= addr_d;
      end
   end

endmodule

// File: rtl/model_matrix_integer_transmitter.sv
// Source end of the matrix element stream: fetches each element from word memory and hands it
// to the consumer one at a time. MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN emits in column-major order.
module model_matrix_integer_transmitter
   import model_matrix_pkg::*;
#(
   parameter int DATA_SIZE    = DEF_DATA_SIZE,
   parameter int CONTROL_SIZE = DEF_CONTROL_SIZE
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 NEXT_ENABLE,
   output logic                 DATA_OUT_I_ENABLE,
   output logic                 DATA_OUT_J_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_I_IN,
   input  logic [DATA_SIZE-1:0] SIZE_J_IN,
   output logic [DATA_SIZE-1:0] MEMORY_ADDRESS_OUT,
   output logic                 MEMORY_READ_ENABLE,
   input  logic [DATA_SIZE-1:0] MEMORY_DATA_IN,
   output logic [DATA_SIZE-1:0] DATA_OUT
);

   state_t               state_q, state_d;
   logic [DATA_SIZE-1:0] data_buf_q, data_buf_d;
   logic [DATA_SIZE-1:0] data_out_q, data_out_d;
   logic                 i_enable_q, i_enable_d;
   logic                 j_enable_q, j_enable_d;
   logic                 ready_q, ready_d;

   logic                 cnt_start;
   logic                 cnt_step;
   logic [DATA_SIZE-1:0] cnt_addr;
   logic                 cnt_first;
   logic                 cnt_last;

   model_matrix_index_counter #(
      .DATA_SIZE    (DATA_SIZE),
      .CONTROL_SIZE (CONTROL_SIZE)
   ) u_index_counter (
      .clk_i    (CLK),
      .rst_i    (RST),
      .start_i  (cnt_start),
      .size_i_i (SIZE_I_IN),
      .size_j_i (SIZE_J_IN),
      .step_i   (cnt_step),
      .addr_o   (cnt_addr),
      .first_o  (cnt_first),
      .last_o   (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      data_buf_d = data_buf_q;
      data_out_d = data_out_q;
      i_enable_d = 1'b0;
      j_enable_d = 1'b0;
      ready_d    = 1'b0;
      cnt_start  = 1'b0;
      cnt_step   = 1'b0;
      unique case (state_q)
         STARTER: begin
            if (START) begin
               cnt_start = 1'b1;
               if (size_is_zero(DEF_DATA_SIZE'(SIZE_I_IN), DEF_DATA_SIZE'(SIZE_J_IN))) begin
                  ready_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            data_buf_d = MEMORY_DATA_IN;
            state_d    = EMIT;
         end
         EMIT: begin
            data_out_d = data_buf_q;
            i_enable_d = cnt_first;
            j_enable_d = !cnt_first;
            state_d    = WAIT;
         end
         WAIT: begin
            if (NEXT_ENABLE) begin
               if (cnt_last) begin
                  ready_d = 1'b1;
                  state_d = STARTER;
               end else begin
                  cnt_step = 1'b1;
                  state_d  = FETCH;
               end
            end
         end
         default: begin
            state_d = STARTER;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= STARTER;
         data_buf_q <= '0;
         data_out_q <= '0;
         i_enable_q <= 1'b0;
         j_enable_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_buf_q <= data_buf_d;
         data_out_q <= data_out_d;
         i_enable_q <= i_enable_d;
         j_enable_q <= j_enable_d;
         ready_q    <= ready_d;
      end
   end

   // The strobe is decoded from the registered state, so it never depends on an input.
   assign MEMORY_READ_ENABLE = (state_q == FETCH);
   assign MEMORY_ADDRESS_OUT = cnt_addr;
   assign DATA_OUT           = data_out_q;
   assign DATA_OUT_I_ENABLE  = i_enable_q;
   assign DATA_OUT_J_ENABLE  = j_enable_q;
   assign READY              = ready_q;

endmodule

// File: tb/tb_model_matrix_integer_transmitter.sv
// Randomised scoreboard bench for model_matrix_integer_transmitter; the expected order follows
// MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN when it is defined.
module tb_model_matrix_integer_transmitter;

   localparam int W = 64;
`ifdef MODEL_MATRIX_TRANSMITTER_TRANSPOSE_EN
   localparam bit TRANSPOSE = 1'b1;
`else
   localparam bit TRANSPOSE = 1'b0;
`endif

   typedef struct {
      int          kind;   // 0 = I-pulse, 1 = J-pulse, 2 = READY
      logic [W-1:0] data;
   } ev_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic         ready;
   logic         next_enable;
   logic         data_out_i_enable;
   logic         data_out_j_enable;
   logic [W-1:0] size_i;
   logic [W-1:0] size_j;
   logic [W-1:0] mem_addr;
   logic         mem_re;
   logic [W-1:0] mem_rdata;
   logic [W-1:0] data_out;

   logic [W-1:0] mem [64];
   ev_t          eq[$];
   logic [W-1:0] aq[$];
   logic [W-1:0] dseq[$];
   int           n_cmp;
   int           n_bad;
   bit           hold_ne;

   model_matrix_integer_transmitter dut (
      .CLK                (clk),
      .RST                (rst),
      .START              (start),
      .READY              (ready),
      .NEXT_ENABLE        (next_enable),
      .DATA_OUT_I_ENABLE  (data_out_i_enable),
      .DATA_OUT_J_ENABLE  (data_out_j_enable),
      .SIZE_I_IN          (size_i),
      .SIZE_J_IN          (size_j),
      .MEMORY_ADDRESS_OUT (mem_addr),
      .MEMORY_READ_ENABLE (mem_re),
      .MEMORY_DATA_IN     (mem_rdata),
      .DATA_OUT           (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr[5:0]];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic fail_event(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event seen, none expected", name);
   endtask

   // Reference traversal: plain nested loops over the logical matrix, address = i*SJ + j.
   task automatic build_model(input int si, input int sj);
      int   outer;
      int   inner;
      int   i;
      int   j;
      int   addr;
      ev_t  e;
      outer = TRANSPOSE ? sj : si;
      inner = TRANSPOSE ? si : sj;
      dseq.delete();
      for (int a = 0; a < outer; a++) begin
         for (int b = 0; b < inner; b++) begin
            i      = TRANSPOSE ? b : a;
            j      = TRANSPOSE ? a : b;
            addr   = i * sj + j;
            aq.push_back(W'(addr));
            e.kind = (b == 0) ? 0 : 1;
            e.data = mem[addr];
            eq.push_back(e);
            dseq.push_back(mem[addr]);
         end
      end
      e.kind = 2;
      e.data = '0;
      eq.push_back(e);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe, pulse or READY.
   initial begin
      ev_t e;
      forever begin
         cyc();
         if (mem_re) begin
            if (aq.size() == 0) fail_event("unexpected_read");
            else check("read_addr", mem_addr, aq.pop_front());
         end
         if (data_out_i_enable && data_out_j_enable) begin
            fail_event("both_pulses");
         end else if (data_out_i_enable || data_out_j_enable) begin
            if (eq.size() == 0 || eq[0].kind == 2) begin
               fail_event("unexpected_pulse");
            end else begin
               e = eq.pop_front();
               check("pulse_is_j", {63'd0, data_out_j_enable}, (e.kind == 1) ? 64'd1 : 64'd0);
               check("element_data", data_out, e.data);
            end
         end
         if (ready) begin
            if (eq.size() == 0 || eq[0].kind != 2) fail_event("unexpected_ready");
            else begin
               e = eq.pop_front();
               check("ready_event", {63'd0, ready}, 64'd1);
            end
         end
      end
   end

   task automatic step_until(input bit want_ready, output int lat);
      lat = 0;
      forever begin
         cyc();
         lat++;
         start = 1'b0;
         if (!hold_ne) next_enable = 1'b0;
         if (want_ready ? ready : (data_out_i_enable || data_out_j_enable)) break;
         if (lat >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no event after %0d cycles, required one", lat);
            break;
         end
      end
   endtask

   task automatic check_all_zero();
      check("rst_ready", {63'd0, ready}, 64'd0);
      check("rst_i_enable", {63'd0, data_out_i_enable}, 64'd0);
      check("rst_j_enable", {63'd0, data_out_j_enable}, 64'd0);
      check("rst_read_enable", {63'd0, mem_re}, 64'd0);
      check("rst_address", mem_addr, 64'd0);
      check("rst_data_out", data_out, 64'd0);
   endtask

   task automatic run_matrix(input int si, input int sj, input int delay, input bit hold,
                             input int spur_at, input int abort_after);
      int lat;
      int n;
      n = si * sj;
      $display("run %0dx%0d delay=%0d hold=%0d", si, sj, delay, hold);
      build_model(si, sj);
      hold_ne     = hold;
      next_enable = hold;
      size_i      = W'(si);
      size_j      = W'(sj);
      start       = 1'b1;
      if (n == 0) begin
         cyc();
         start = 1'b0;
         check("zero_size_ready", {63'd0, ready}, 64'd1);
         repeat (4) cyc();
         next_enable = 1'b0;
         hold_ne     = 1'b0;
         return;
      end
      step_until(1'b0, lat);
      check("first_latency", W'(lat), 64'd4);
      for (int k = 0; k < n; k++) begin
         if (k == abort_after) begin
            rst         = 1'b1;
            next_enable = 1'b0;
            hold_ne     = 1'b0;
            eq.delete();
            aq.delete();
            cyc();
            rst = 1'b0;
            check_all_zero();
            return;
         end
         if (hold) begin
            if (k == spur_at) start = 1'b1;
         end else begin
            repeat (delay) begin
               cyc();
               check("data_hold", data_out, dseq[k]);
            end
            next_enable = 1'b1;
         end
         step_until(k == n - 1, lat);
         if (k == n - 1) check("ready_latency", W'(lat), 64'd1);
         else            check("elem_latency", W'(lat), 64'd4);
      end
      next_enable = 1'b0;
      hold_ne     = 1'b0;
      cyc();
   endtask

   task automatic fill_random();
      for (int k = 0; k < 64; k++) mem[k] = {$urandom, $urandom};
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      hold_ne     = 1'b0;
      rst         = 1'b1;
      start       = 1'b0;
      next_enable = 1'b0;
      size_i      = '0;
      size_j      = '0;
      for (int k = 0; k < 64; k++) mem[k] = W'(10 + k);
      repeat (3) cyc();
      check_all_zero();
      rst = 1'b0;
      cyc();

      run_matrix(2, 3, 2, 1'b0, -1, -1);
      run_matrix(0, 4, 0, 1'b0, -1, -1);
      fill_random();
      run_matrix(3, 3, 0, 1'b1, 4, -1);
      run_matrix(3, 3, 1, 1'b0, -1, 3);
      fill_random();
      run_matrix(1, 1, 0, 1'b0, -1, -1);
      run_matrix(1, 1, 50, 1'b0, -1, -1);

      for (int t = 0; t < 10; t++) begin
         fill_random();
         run_matrix(int'($urandom_range(0, 6)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 2, -1);
      end

      repeat (5) cyc();
      check("pending_events", W'(eq.size()), 64'd0);
      check("pending_reads", W'(aq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
